// File: rtl/cover_toggle_tracker.sv
// Toggle-coverage collector: latches per-point hit strobes into a pending bitmap and
// drains them lowest-index-first as absolute cover indices over a valid/ready port.

module cover_toggle_lane #(
   parameter bit STICKY = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic valid_i,
   input  logic capture_i,
   input  logic clear_i,
   input  logic load_i,
   output logic pending_o,
   output logic reported_nxt_o,
   output logic drop_o
);
   logic pending_q, pending_d;
   logic reported_q, reported_d;
   logic hit;
   logic new_hit;

   assign hit     = capture_i & valid_i;
   assign new_hit = STICKY ? (hit & ~reported_q) : hit;

   always_comb begin
      pending_d  = (pending_q & ~load_i) | new_hit;
      reported_d = STICKY ? (reported_q | hit) : 1'b0;
      if (clear_i) begin
         pending_d  = 1'b0;
         reported_d = 1'b0;
      end
   end

   // A re-hit on the edge the bit is being loaded just re-arms it; only a hit on a
   // bit that stays pending is lost.
   assign drop_o         = !STICKY && hit && pending_q && !load_i;
   assign pending_o      = pending_q;
   assign reported_nxt_o = reported_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         pending_q  <= 1'b0;
         reported_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         reported_q <= reported_d;
      end
   end
endmodule

module cover_toggle_tracker #(
   parameter int WIDTH       = 20,
   parameter int COVER_INDEX = 0,
   parameter int COVER_TOTAL = 8940,
   parameter int IDX_W       = 64,
   parameter bit STICKY      = 1'b1,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] valid,
   input  logic             enable,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] drop_count,
   output logic             all_covered
);
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_params
      $error("cover_toggle_tracker: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
   end

   typedef enum logic {EMPTY, HOLD} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   out_index_q, out_index_d;
   logic [CNT_W-1:0]   hit_q, hit_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               allcov_q, allcov_d;

   logic [WIDTH-1:0]   pending;
   logic [WIDTH-1:0]   reported_nxt;
   logic [WIDTH-1:0]   drop_vec;
   logic [WIDTH-1:0]   lowest;
   logic [WIDTH-1:0]   load_vec;
   logic [BIT_W-1:0]   load_bit;
   logic               load_en;
   logic               capture;
   logic               fire;

   assign capture = enable & ~clear;
   assign fire    = (state_q == HOLD) & out_ready;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      cover_toggle_lane #(.STICKY(STICKY)) u_lane (
         .clock          (clock),
         .reset          (reset),
         .valid_i        (valid[i]),
         .capture_i      (capture),
         .clear_i        (clear),
         .load_i         (load_vec[i]),
         .pending_o      (pending[i]),
         .reported_nxt_o (reported_nxt[i]),
         .drop_o         (drop_vec[i])
      );
   end

   // Two's-complement trick isolates the lowest set pending bit as a one-hot.
   assign lowest   = pending & (~pending + WIDTH'(1));
   assign load_vec = load_en ? lowest : '0;

   always_comb begin
      load_bit = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (lowest[i]) load_bit = load_bit | BIT_W'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      load_en     = 1'b0;
      out_index_d = out_index_q;
      case (state_q)
         EMPTY: begin
            if (|pending) begin
               load_en = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (fire) begin
               if (|pending) load_en = 1'b1;
               else          state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (load_en) out_index_d = IDX_W'(COVER_INDEX) + IDX_W'(load_bit);
   end

   always_comb begin
      hit_d    = hit_q;
      drop_d   = drop_q;
      allcov_d = STICKY ? (&reported_nxt) : 1'b0;
      if (fire && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
      if ((|drop_vec) && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
      if (clear) begin
         hit_d  = '0;
         drop_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= EMPTY;
         out_index_q <= '0;
         hit_q       <= '0;
         drop_q      <= '0;
         allcov_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_index_q <= out_index_d;
         hit_q       <= hit_d;
         drop_q      <= drop_d;
         allcov_q    <= allcov_d;
      end
   end

   assign out_valid   = (state_q == HOLD);
   assign out_index   = out_index_q;
   assign hit_count   = hit_q;
   assign drop_count  = drop_q;
   assign all_covered = allcov_q;
endmodule

// File: tb/tb_cover_toggle_tracker.sv
// Bench: a sticky and a non-sticky tracker driven in parallel, checked against a
// cycle-level reference model plus directed tables and sequences.
module tb_cover_toggle_tracker;
   localparam int W  = 20;
   localparam int CI = 100;

   logic          clock = 1'b0;
   logic          reset;
   logic [W-1:0]  valid;
   logic          enable;
   logic          clear;
   logic          out_ready;

   logic          ov1, ac1, ov0, ac0;
   logic [63:0]   idx1, idx0;
   logic [15:0]   hit1, drop1;
   logic [3:0]    hit0, drop0;

   int n_chk  = 0;
   int n_pass = 0;

   // model state: index 0 = non-sticky (4-bit counters), 1 = sticky (16-bit counters)
   logic [W-1:0]  m_pend [2];
   logic [W-1:0]  m_rep  [2];
   logic          m_hold [2];
   logic [63:0]   m_idx  [2];
   int            m_hit  [2];
   int            m_drop [2];
   logic          m_ac   [2];

   always #5 clock = ~clock;

   cover_toggle_tracker #(.WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(8940), .IDX_W(64),
                          .STICKY(1'b1), .CNT_W(16)) u_dut1 (
      .clock(clock), .reset(reset), .valid(valid), .enable(enable), .clear(clear),
      .out_valid(ov1), .out_ready(out_ready), .out_index(idx1),
      .hit_count(hit1), .drop_count(drop1), .all_covered(ac1));

   cover_toggle_tracker #(.WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(8940), .IDX_W(64),
                          .STICKY(1'b0), .CNT_W(4)) u_dut0 (
      .clock(clock), .reset(reset), .valid(valid), .enable(enable), .clear(clear),
      .out_valid(ov0), .out_ready(out_ready), .out_index(idx0),
      .hit_count(hit0), .drop_count(drop0), .all_covered(ac0));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic model_step(input int s);
      int  ld;
      int  cmax;
      bit  fire;
      bit  dropped;
      cmax = (s == 1) ? 65535 : 15;
      fire = m_hold[s] && out_ready;
      if (!reset) begin
         m_pend[s] = '0; m_rep[s] = '0; m_hold[s] = 1'b0; m_idx[s] = '0;
         m_hit[s] = 0; m_drop[s] = 0; m_ac[s] = 1'b0;
         return;
      end
      ld = -1;
      if (!m_hold[s] || fire) begin
         for (int b = 0; b < W; b++) if (m_pend[s][b]) begin ld = b; break; end
      end
      if (ld >= 0) begin
         m_hold[s] = 1'b1;
         m_idx[s] = 64'(CI + ld);
         m_pend[s][ld] = 1'b0;
      end else if (fire) m_hold[s] = 1'b0;
      dropped = 0;
      if (s == 0 && enable && !clear)
         for (int b = 0; b < W; b++) if (valid[b] && m_pend[s][b]) dropped = 1;
      if (clear) begin
         m_hit[s] = 0; m_drop[s] = 0; m_pend[s] = '0; m_rep[s] = '0;
      end else begin
         if (fire && m_hit[s] < cmax) m_hit[s]++;
         if (dropped && m_drop[s] < cmax) m_drop[s]++;
         if (enable)
            for (int b = 0; b < W; b++) if (valid[b]) begin
               if (s == 0 || !m_rep[s][b]) m_pend[s][b] = 1'b1;
               if (s == 1) m_rep[s][b] = 1'b1;
            end
      end
      m_ac[s] = (s == 1) && (&m_rep[s]);
   endtask

   task automatic tick();
      @(posedge clock);
      model_step(0);
      model_step(1);
      @(negedge clock);
      chk("s1.out_valid", 64'(ov1), 64'(m_hold[1]));
      if (m_hold[1]) chk("s1.out_index", idx1, m_idx[1]);
      chk("s1.hit_count", 64'(hit1), 64'(m_hit[1]));
      chk("s1.drop_count", 64'(drop1), 64'(m_drop[1]));
      chk("s1.all_covered", 64'(ac1), 64'(m_ac[1]));
      chk("s0.out_valid", 64'(ov0), 64'(m_hold[0]));
      if (m_hold[0]) chk("s0.out_index", idx0, m_idx[0]);
      chk("s0.hit_count", 64'(hit0), 64'(m_hit[0]));
      chk("s0.drop_count", 64'(drop0), 64'(m_drop[0]));
      chk("s0.all_covered", 64'(ac0), 64'(m_ac[0]));
   endtask

   task automatic pulse_clear();
      valid = '0; clear = 1'b1; tick(); clear = 1'b0;
   endtask

   typedef struct {
      logic         rst;
      logic         rdy;
      logic [W-1:0] vld;
      logic         exp_ov;
      logic [63:0]  exp_idx;
      logic [15:0]  exp_hit;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int cnt;
      int exp_next;
      reset = 1'b0; valid = '0; enable = 1'b1; clear = 1'b0; out_ready = 1'b0;

      tbl[0] = '{1'b0, 1'b1, 20'hFFFFF, 1'b0, 64'd0,   16'd0};
      tbl[1] = '{1'b0, 1'b1, 20'hFFFFF, 1'b0, 64'd0,   16'd0};
      tbl[2] = '{1'b1, 1'b1, 20'h00000, 1'b0, 64'd0,   16'd0};
      tbl[3] = '{1'b1, 1'b1, 20'h20008, 1'b0, 64'd0,   16'd0};
      tbl[4] = '{1'b1, 1'b1, 20'h00000, 1'b1, 64'd103, 16'd0};
      tbl[5] = '{1'b1, 1'b1, 20'h00000, 1'b1, 64'd117, 16'd1};
      tbl[6] = '{1'b1, 1'b1, 20'h00000, 1'b0, 64'd117, 16'd2};
      tbl[7] = '{1'b1, 1'b1, 20'h00000, 1'b0, 64'd117, 16'd2};

      for (int i = 0; i < 8; i++) begin
         reset = tbl[i].rst; out_ready = tbl[i].rdy; valid = tbl[i].vld;
         tick();
         chk($sformatf("tbl%0d.out_valid", i), 64'(ov1), 64'(tbl[i].exp_ov));
         chk($sformatf("tbl%0d.out_index", i), idx1, tbl[i].exp_idx);
         chk($sformatf("tbl%0d.hit_count", i), 64'(hit1), 64'(tbl[i].exp_hit));
         chk($sformatf("tbl%0d.all_covered", i), 64'(ac1), 64'd0);
      end

      // sticky: a long hit reports once; after clear it reports again
      pulse_clear();
      out_ready = 1'b1; cnt = 0;
      for (int i = 0; i < 14; i++) begin
         valid = (i < 10) ? 20'h00020 : '0;
         if (ov1 && idx1 == 64'd105) cnt++;
         tick();
      end
      chk("sticky_once.reports", 64'(cnt), 64'd1);
      chk("sticky_once.hit_count", 64'(hit1), 64'd1);
      pulse_clear();
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         valid = (i == 0) ? 20'h00020 : '0;
         if (ov1 && idx1 == 64'd105) cnt++;
         tick();
      end
      chk("sticky_rearm.reports", 64'(cnt), 64'd1);
      chk("sticky_rearm.hit_count", 64'(hit1), 64'd1);

      // backpressure with every point hit, then full ascending drain
      pulse_clear();
      out_ready = 1'b0; valid = '1;
      for (int i = 0; i < 8; i++) tick();
      chk("bp.out_valid", 64'(ov1), 64'd1);
      chk("bp.out_index", idx1, 64'd100);
      valid = '0; out_ready = 1'b1; cnt = 0; exp_next = CI;
      for (int i = 0; i < 24; i++) begin
         if (ov1) begin
            chk("drain.order", idx1, 64'(exp_next));
            exp_next++; cnt++;
         end
         tick();
      end
      chk("drain.reports", 64'(cnt), 64'd20);
      chk("drain.hit_count", 64'(hit1), 64'd20);
      chk("drain.all_covered", 64'(ac1), 64'd1);

      // non-sticky drops while the output slot is occupied
      pulse_clear();
      out_ready = 1'b0; valid = 20'h00001; tick();
      valid = '0; tick();
      for (int i = 0; i < 4; i++) begin valid = 20'h00004; tick(); end
      valid = '0; tick();
      chk("drop.drop_count", 64'(drop0), 64'd3);
      out_ready = 1'b1; cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (ov0 && idx0 == 64'd102) cnt++;
         tick();
      end
      chk("drop.reports102", 64'(cnt), 64'd1);

      // clear while holding an output: index kept, counters zeroed, later fire counts
      pulse_clear();
      out_ready = 1'b0; valid = 20'h00080; tick();
      valid = '0; tick(); tick();
      pulse_clear();
      chk("clr_hold.out_valid", 64'(ov1), 64'd1);
      chk("clr_hold.out_index", idx1, 64'd107);
      chk("clr_hold.hit_count", 64'(hit1), 64'd0);
      out_ready = 1'b1; tick();
      chk("clr_hold.fire_hit", 64'(hit1), 64'd1);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         reset     = ($urandom_range(0, 99) != 0);
         enable    = ($urandom_range(0, 7) != 0);
         clear     = ($urandom_range(0, 39) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         valid     = W'($urandom & $urandom & $urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
